// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: FIFO entry layout, write-source
// encoding and default widths.
package wb_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int RD_W      = 5;

    typedef struct packed {
        logic [RD_W-1:0]     rd;
        logic [XLEN_DEF-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE   = 2'd0,
        WB_ALU    = 2'd1,
        WB_FIFO   = 2'd2,
        WB_BYPASS = 2'd3
    } wb_src_e;

    // Long-latency sources retire a scoreboard entry when they commit.
    function automatic logic is_lsu_src(input wb_src_e src);
        return (src == WB_FIFO) || (src == WB_BYPASS);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port
// is free. Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  entry_t                   i_data,
    input  logic                     i_pop,
    output entry_t                   o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Entry storage; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Read/write pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Drives the single register-file write port from the ALU and a buffered
// long-latency unit, and tracks in-flight long-latency destinations.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alu_valid,
    input  logic [RD_W-1:0]              alu_rd,
    input  logic [XLEN-1:0]              alu_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [RD_W-1:0]              lsu_rd,
    input  logic [XLEN-1:0]              lsu_data,
    input  logic                         issue_valid,
    input  logic [RD_W-1:0]              issue_rd,
    output logic                         reg_write,
    output logic [RD_W-1:0]              rd,
    output logic [XLEN-1:0]              write_data,
    output logic [NREGS-1:0]             busy,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [XLEN-1:0] data;
    } wb_ent_t;

    wb_ent_t                     w_fifo_in;
    wb_ent_t                     w_fifo_head;
    logic                        w_fifo_full;
    logic                        w_fifo_empty;
    logic [$clog2(BUF_DEPTH):0]  w_fifo_count;
    logic                        w_lsu_hs;
    logic                        w_push;
    logic                        w_pop;
    wb_src_e                     w_src;
    logic [RD_W-1:0]             w_sel_rd;
    logic [XLEN-1:0]             w_sel_data;
    logic [NREGS-1:0]            w_busy_nxt;

    logic                        r_reg_write;
    logic [RD_W-1:0]             r_rd;
    logic [XLEN-1:0]             r_write_data;
    logic [NREGS-1:0]            r_busy;

    assign lsu_ready  = !w_fifo_full;
    assign w_lsu_hs   = lsu_valid && lsu_ready;
    assign w_fifo_in  = '{rd: lsu_rd, data: lsu_data};
    assign w_pop      = (w_src == WB_FIFO);
    // A bypassed result goes straight to the port and must not also be queued.
    assign w_push     = w_lsu_hs && (w_src != WB_BYPASS);

    assign reg_write  = r_reg_write;
    assign rd         = r_rd;
    assign write_data = r_write_data;
    assign busy       = r_busy;
    assign buf_count  = w_fifo_count;

    wb_fifo #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (wb_ent_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_fifo_in),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Fixed-priority source select: ALU, then queued results, then bypass.
    always_comb begin
        w_src      = WB_NONE;
        w_sel_rd   = {RD_W{1'b0}};
        w_sel_data = {XLEN{1'b0}};
        if (alu_valid) begin
            w_src      = WB_ALU;
            w_sel_rd   = alu_rd;
            w_sel_data = alu_data;
        end else if (!w_fifo_empty) begin
            w_src      = WB_FIFO;
            w_sel_rd   = w_fifo_head.rd;
            w_sel_data = w_fifo_head.data;
        end else if (w_lsu_hs) begin
            w_src      = WB_BYPASS;
            w_sel_rd   = lsu_rd;
            w_sel_data = lsu_data;
        end else begin
            w_src      = WB_NONE;
        end
    end

    // Scoreboard update; a same-cycle issue overrides the retiring clear.
    always_comb begin
        w_busy_nxt = r_busy;
        if (is_lsu_src(w_src)) begin
            w_busy_nxt[w_sel_rd] = 1'b0;
        end else begin
            w_busy_nxt = r_busy;
        end
        if (issue_valid && (issue_rd != {RD_W{1'b0}})) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end else begin
            w_busy_nxt[0] = 1'b0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Registered write port and scoreboard; x0 is never written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_rd         <= {RD_W{1'b0}};
            r_write_data <= {XLEN{1'b0}};
            r_busy       <= {NREGS{1'b0}};
        end else begin
            r_busy <= w_busy_nxt;
            if (w_src != WB_NONE) begin
                r_reg_write  <= (w_sel_rd != {RD_W{1'b0}});
                r_rd         <= w_sel_rd;
                r_write_data <= w_sel_data;
            end else begin
                r_reg_write  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed plus randomized checks of writeback_arbiter against a queue-based
// model of the write-port priority rules and the destination scoreboard.
module tb_writeback_arbiter;

    localparam int BUF_DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [31:0] busy;
    logic [1:0]  buf_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [36:0] mdl_q[$];
    logic [36:0] lsu_stream[$];
    logic [31:0] mdl_busy;
    logic        exp_we;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;

    always #5 clk = ~clk;

    writeback_arbiter #(.XLEN(32), .NREGS(32), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .reg_write   (reg_write),
        .rd          (rd),
        .write_data  (write_data),
        .busy        (busy),
        .buf_count   (buf_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_busy = 32'd0;
        exp_we   = 1'b0;
        exp_rd   = 5'd0;
        exp_data = 32'd0;
    endtask

    task automatic check_outputs();
        chk("reg_write",  64'(reg_write),  64'(exp_we));
        chk("rd",         64'(rd),         64'(exp_rd));
        chk("write_data", 64'(write_data), 64'(exp_data));
        chk("busy",       64'(busy),       64'(mdl_busy));
        chk("buf_count",  64'(buf_count),  64'(mdl_q.size()));
    endtask

    // One clock: drive the lsu stream head, predict, clock, compare.
    task automatic step();
        logic        rdy;
        logic        hs;
        logic        wr;
        logic        clr;
        logic [36:0] w;
        logic [36:0] lsu_e;
        wr  = 1'b0;
        clr = 1'b0;
        w   = 37'd0;
        if (lsu_stream.size() > 0) begin
            lsu_valid = 1'b1;
            lsu_e     = lsu_stream[0];
            lsu_rd    = lsu_e[36:32];
            lsu_data  = lsu_e[31:0];
        end else begin
            lsu_valid = 1'b0;
            lsu_e     = 37'd0;
        end
        rdy = (mdl_q.size() < BUF_DEPTH);
        chk("lsu_ready", 64'(lsu_ready), 64'(rdy));
        hs = lsu_valid && rdy;
        if (alu_valid) begin
            w  = {alu_rd, alu_data};
            wr = 1'b1;
            if (hs) mdl_q.push_back(lsu_e);
        end else if (mdl_q.size() > 0) begin
            w   = mdl_q.pop_front();
            wr  = 1'b1;
            clr = 1'b1;
            if (hs) mdl_q.push_back(lsu_e);
        end else if (hs) begin
            w   = lsu_e;
            wr  = 1'b1;
            clr = 1'b1;
        end
        if (wr) begin
            exp_rd   = w[36:32];
            exp_data = w[31:0];
            exp_we   = (w[36:32] != 5'd0);
        end else begin
            exp_we   = 1'b0;
        end
        if (clr) mdl_busy[w[36:32]] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) mdl_busy[issue_rd] = 1'b1;
        mdl_busy[0] = 1'b0;
        if (hs) void'(lsu_stream.pop_front());
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic cyc(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic iv, input logic [4:0] ird);
        alu_valid   = av;
        alu_rd      = ard;
        alu_data    = ad;
        issue_valid = iv;
        issue_rd    = ird;
        step();
    endtask

    initial begin
        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'd0;
        lsu_valid   = 1'b0;
        lsu_rd      = 5'd0;
        lsu_data    = 32'd0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        model_reset();
        #12;
        check_outputs();
        chk("reset_lsu_ready", 64'(lsu_ready), 64'd1);
        #1 reset = 1'b0;

        // ALU write with one-cycle latency
        cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        chk("alu_first_rd",   64'(rd),         64'd5);
        chk("alu_first_data", 64'(write_data), 64'hDEADBEEF);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Issue, then bypassed long-latency result clears the scoreboard
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        chk("busy7_set", 64'(busy[7]), 64'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        lsu_stream.push_back({5'd7, 32'h00001234});
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("bypass_rd",    64'(rd),         64'd7);
        chk("bypass_data",  64'(write_data), 64'h1234);
        chk("busy7_clear",  64'(busy[7]),    64'd0);

        // ALU stream fills the FIFO and backpressures; drain order 8,9,10
        lsu_stream.push_back({5'd8,  32'h00008008});
        lsu_stream.push_back({5'd9,  32'h00009009});
        lsu_stream.push_back({5'd10, 32'h0000A00A});
        cyc(1'b1, 5'd1, 32'h11, 1'b0, 5'd0);
        cyc(1'b1, 5'd2, 32'h22, 1'b0, 5'd0);
        chk("full_count", 64'(buf_count), 64'd2);
        chk("full_ready", 64'(lsu_ready), 64'd0);
        cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
        cyc(1'b1, 5'd4, 32'h44, 1'b0, 5'd0);
        chk("alu4_rd", 64'(rd), 64'd4);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("drain8_rd", 64'(rd), 64'd8);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("drain9_rd", 64'(rd), 64'd9);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("drain10_rd", 64'(rd), 64'd10);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Writes to x0 are consumed but never enabled
        lsu_stream.push_back({5'd0, 32'h0000BAD0});
        cyc(1'b1, 5'd0, 32'h0000BAD1, 1'b0, 5'd0);
        chk("x0_alu_we",  64'(reg_write), 64'd0);
        chk("x0_count1",  64'(buf_count), 64'd1);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("x0_fifo_we", 64'(reg_write), 64'd0);
        chk("x0_count0",  64'(buf_count), 64'd0);

        // Re-issue on the commit cycle keeps the bit set
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        lsu_stream.push_back({5'd12, 32'h0000C0DE});
        cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
        chk("reissue_we",    64'(reg_write), 64'd1);
        chk("reissue_busy",  64'(busy[12]),  64'd1);
        lsu_stream.push_back({5'd12, 32'h0000C0DF});
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("busy12_clear",  64'(busy[12]),  64'd0);

        // Asynchronous reset with a full FIFO and pending destinations
        lsu_stream.push_back({5'd20, 32'h20});
        lsu_stream.push_back({5'd21, 32'h21});
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd8);
        cyc(1'b1, 5'd2, 32'h2, 1'b1, 5'd9);
        chk("pre_rst_busy",  64'(busy),      64'h300);
        chk("pre_rst_count", 64'(buf_count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_reg_write", 64'(reg_write), 64'd0);
        chk("arst_busy",      64'(busy),      64'd0);
        chk("arst_count",     64'(buf_count), 64'd0);
        alu_valid   = 1'b0;
        issue_valid = 1'b0;
        lsu_valid   = 1'b0;
        lsu_stream.delete();
        model_reset();
        #1 reset = 1'b0;
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        chk("post_rst_no_write", 64'(reg_write), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (lsu_stream.size() == 0 && $urandom_range(0, 99) < 35) begin
                lsu_stream.push_back({5'($urandom_range(0, 31)), 32'($urandom)});
            end
            cyc(1'($urandom_range(0, 99) < 40), 5'($urandom_range(0, 31)), 32'($urandom),
                1'($urandom_range(0, 99) < 20), 5'($urandom_range(0, 31)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
